// File: rtl/spi_master_tx_if.sv
// Byte-stream handshake and SPI pin bundle for the mode-0 SPI master.
// The master modport is the SPI master's view; the slave modport is the view of
// the logic that feeds bytes in and drives MISO.
interface spi_master_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              hold;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              SCLK;
  logic              MOSI;
  logic              MISO;
  logic              SSEL;

  modport master (
    input  tx_data, tx_valid, hold, MISO,
    output tx_ready, rx_data, rx_valid, busy, SCLK, MOSI, SSEL
  );

  modport slave (
    output tx_data, tx_valid, hold, MISO,
    input  tx_ready, rx_data, rx_valid, busy, SCLK, MOSI, SSEL
  );
endinterface

// File: rtl/spi_master_tx.sv
// Mode-0 SPI master (CPOL=0, CPHA=0), MSB first, one DATA_W-bit word per
// transfer, with optional bursts that keep SSEL low between words.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | SSEL high, SCLK low, waiting for tx_valid
// SETUP | SSEL low, MSB on MOSI, CLK_DIV cycles before the first rise
// XFER  | SCLK toggling every CLK_DIV cycles, MISO sampled on each rise
// LAST  | one cycle after the final fall; rx_valid, optional burst accept
// GAP   | SSEL high for CLK_DIV cycles of deselect time
module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  spi_master_tx_if.master bus
);

  localparam int                BIT_W    = $clog2(DATA_W) + 1;
  localparam logic [7:0]        DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0]        DIV_ONE  = 8'd1;
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    LAST  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_ready;
  logic              busy;
  logic              sclk;
  logic              mosi;
  logic              ssel;

  // Sequencer: half-period down-counter, bit counter, shift registers and
  // all registered pin/handshake outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ssel     <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_valid) begin
            tx_shift <= bus.tx_data;
            mosi     <= bus.tx_data[DATA_W-1];
            ssel     <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            div_cnt  <= DIV_LOAD;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == '0) begin
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[DATA_W-2:0], bus.MISO};
            bit_cnt  <= bit_cnt + BIT_ONE;
            div_cnt  <= DIV_LOAD;
            state    <= XFER;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        XFER: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_LOAD;
            if (sclk) begin
              sclk <= 1'b0;
              // The fall after the last rise ends the word; MOSI keeps the LSB.
              if (bit_cnt == BIT_LAST) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                tx_ready <= 1'b1;
                state    <= LAST;
              end else begin
                tx_shift <= tx_shift << 1;
                mosi     <= tx_shift[DATA_W-2];
              end
            end else begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[DATA_W-2:0], bus.MISO};
              bit_cnt  <= bit_cnt + BIT_ONE;
            end
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        LAST: begin
          tx_ready <= 1'b0;
          div_cnt  <= DIV_LOAD;
          bit_cnt  <= '0;
          // A burst continues only if the next word is already offered;
          // hold alone never stalls the bus.
          if (bus.hold && bus.tx_valid) begin
            tx_shift <= bus.tx_data;
            mosi     <= bus.tx_data[DATA_W-1];
            state    <= SETUP;
          end else begin
            ssel  <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          if (div_cnt == '0) begin
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SCLK     = sclk;
  assign bus.MOSI     = mosi;
  assign bus.SSEL     = ssel;
  assign bus.tx_ready = tx_ready;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a CLK_DIV=2 instance exercised with loopback, a
// mode-0 slave model, bursts, ignored requests and mid-transfer reset, plus a
// CLK_DIV=5 instance for phase timing.
`timescale 1ns/1ps
module tb_spi_master_tx;
  localparam int DW    = 8;
  localparam int DIV_A = 2;
  localparam int DIV_B = 5;
  localparam int BOUND = 400;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   errors = 0;
  int   checks = 0;

  always #31 clk = ~clk;

  spi_master_tx_if #(.DATA_W(DW)) bus_a ();
  spi_master_tx_if #(.DATA_W(DW)) bus_b ();

  spi_master_tx #(.CLK_DIV(DIV_A), .DATA_W(DW)) u_dut_a (.CLK(clk), .RST_N(rst_n_a), .bus(bus_a));
  spi_master_tx #(.CLK_DIV(DIV_B), .DATA_W(DW)) u_dut_b (.CLK(clk), .RST_N(rst_n_b), .bus(bus_b));

  // MISO source for instance A: loopback or a mode-0 slave shifting out slave_byte.
  logic          slave_mode = 1'b0;
  logic [DW-1:0] slave_byte = '0;
  logic [DW-1:0] slave_sh   = '0;
  assign bus_a.MISO = slave_mode ? slave_sh[DW-1] : bus_a.MOSI;
  assign bus_b.MISO = bus_b.MOSI;

  // Observation record for instance A (only ever appended / incremented).
  int            cyc = 0, rises = 0, ssel_low = 0, gap_cyc = 0, ssel_rises = 0, rxv_cnt = 0;
  int            rise_cyc_q[$];
  logic          mosi_q[$];
  logic [DW-1:0] rx_q[$];
  int            ssel_rise_rxv_q[$];
  logic          prev_sclk = 1'b0, prev_ssel = 1'b1;

  // Sample instance A 1 ns after each edge; also advances the slave model.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!bus_a.SSEL && prev_ssel) slave_sh = slave_byte;
    else if (!bus_a.SCLK && prev_sclk) slave_sh = slave_sh << 1;
    if (bus_a.SCLK && !prev_sclk) begin
      rises++;
      rise_cyc_q.push_back(cyc);
      mosi_q.push_back(bus_a.MOSI);
    end
    if (!bus_a.SSEL) ssel_low++;
    if (bus_a.SSEL && !prev_ssel) begin
      ssel_rises++;
      ssel_rise_rxv_q.push_back(rxv_cnt);
    end
    if (bus_a.busy && bus_a.SSEL) gap_cyc++;
    if (bus_a.rx_valid) begin
      rxv_cnt++;
      rx_q.push_back(bus_a.rx_data);
    end
    prev_sclk = bus_a.SCLK;
    prev_ssel = bus_a.SSEL;
  end

  // Observation record for instance B: SCLK phase lengths within a select window.
  int            b_rises = 0, b_sess = 0, b_run = 0, b_setup = 0, b_rxv = 0;
  int            b_high_q[$];
  int            b_low_q[$];
  logic [DW-1:0] b_rx = '0;
  logic          b_prev = 1'b0;

  // Sample instance B 1 ns after each edge.
  always @(posedge clk) begin
    #1;
    if (bus_b.SSEL) b_sess = 0;
    if (bus_b.SCLK != b_prev) begin
      if (b_prev) b_high_q.push_back(b_run);
      else if (b_sess > 0) b_low_q.push_back(b_run);
      if (bus_b.SCLK) begin
        b_rises++;
        b_sess++;
      end
      b_run = 1;
    end else begin
      b_run++;
    end
    if (!bus_b.SSEL && b_sess == 0) b_setup++;
    if (bus_b.rx_valid) begin
      b_rxv++;
      b_rx = bus_b.rx_data;
    end
    b_prev = bus_b.SCLK;
  end

  // Reference model: SSEL low time of one word = SETUP + first-rise-to-LAST + LAST.
  function automatic int model_ssel_low(input int div);
    return div + (2 * DW * div - div) + 1;
  endfunction

  // MOSI word as seen on DW consecutive recorded rises, MSB first.
  function automatic logic [DW-1:0] mosi_byte(input int from);
    logic [DW-1:0] b;
    for (int k = 0; k < DW; k++)
      b[DW-1-k] = (from + k < mosi_q.size()) ? mosi_q[from+k] : 1'bx;
    return b;
  endfunction

  function automatic logic [DW-1:0] rx_at(input int idx);
    return (idx < rx_q.size()) ? rx_q[idx] : 'x;
  endfunction

  task automatic send_a(input logic [DW-1:0] d, input logic h);
    @(negedge clk);
    bus_a.tx_data  = d;
    bus_a.hold     = h;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (!(bus_a.tx_ready === 1'b1 && bus_a.busy === 1'b0) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= BOUND) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b tx_ready=%b, required idle within %0d cycles", name, bus_a.busy, bus_a.tx_ready, BOUND);
    end
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.tx_valid = 1'b0; bus_a.hold = 1'b0; bus_a.tx_data = '0;
    bus_b.tx_valid = 1'b0; bus_b.hold = 1'b0; bus_b.tx_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus_a.SCLK !== 1'b0)     begin errors++; $display("FAIL rst_sclk: got %b want 0", bus_a.SCLK); end
    checks++; if (bus_a.SSEL !== 1'b1)     begin errors++; $display("FAIL rst_ssel: got %b want 1", bus_a.SSEL); end
    checks++; if (bus_a.MOSI !== 1'b0)     begin errors++; $display("FAIL rst_mosi: got %b want 0", bus_a.MOSI); end
    checks++; if (bus_a.tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", bus_a.tx_ready); end
    checks++; if (bus_a.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", bus_a.rx_valid); end
    checks++; if (bus_a.busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", bus_a.busy); end
    checks++; if (bus_a.rx_data !== '0)    begin errors++; $display("FAIL rst_rx_data: got %h want 00", bus_a.rx_data); end
    checks++; if (bus_b.SSEL !== 1'b1 || bus_b.SCLK !== 1'b0) begin errors++; $display("FAIL rst_b_pins: got ssel=%b sclk=%b want 1/0", bus_b.SSEL, bus_b.SCLK); end
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus_a.SSEL !== 1'b1 || bus_a.tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_idle: got ssel=%b tx_ready=%b want 1/1", bus_a.SSEL, bus_a.tx_ready); end
  endtask

  task automatic test_loopback_a5();
    int s_r, s_low, s_gap, s_rxv, s_sr, bad;
    slave_mode = 1'b0;
    s_r = rises; s_low = ssel_low; s_gap = gap_cyc; s_rxv = rxv_cnt; s_sr = ssel_rises;
    send_a(8'hA5, 1'b0);
    checks++; if (bus_a.SSEL !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.tx_ready !== 1'b0 || bus_a.MOSI !== 1'b1) begin
      errors++; $display("FAIL a5_start: got ssel=%b busy=%b tx_ready=%b mosi=%b want 0/1/0/1", bus_a.SSEL, bus_a.busy, bus_a.tx_ready, bus_a.MOSI);
    end
    wait_idle_a("a5");
    bad = 0;
    for (int k = s_r + 1; k < rises; k++) if (rise_cyc_q[k] - rise_cyc_q[k-1] != 2 * DIV_A) bad++;
    checks++; if (rises - s_r != DW) begin errors++; $display("FAIL a5_rises: got %0d want %0d", rises - s_r, DW); end
    checks++; if (bad != 0) begin errors++; $display("FAIL a5_rise_spacing: got %0d bad gaps want 0 (spacing %0d)", bad, 2 * DIV_A); end
    checks++; if (mosi_byte(s_r) !== 8'hA5) begin errors++; $display("FAIL a5_mosi: got %h want a5", mosi_byte(s_r)); end
    checks++; if (rxv_cnt - s_rxv != 1) begin errors++; $display("FAIL a5_rxv_count: got %0d want 1", rxv_cnt - s_rxv); end
    checks++; if (rx_at(s_rxv) !== 8'hA5) begin errors++; $display("FAIL a5_rx_data: got %h want a5", rx_at(s_rxv)); end
    checks++; if (ssel_low - s_low != model_ssel_low(DIV_A)) begin errors++; $display("FAIL a5_ssel_low: got %0d want %0d", ssel_low - s_low, model_ssel_low(DIV_A)); end
    checks++; if (gap_cyc - s_gap != DIV_A) begin errors++; $display("FAIL a5_gap: got %0d want %0d", gap_cyc - s_gap, DIV_A); end
    checks++; if (ssel_rises - s_sr != 1) begin errors++; $display("FAIL a5_ssel_rises: got %0d want 1", ssel_rises - s_sr); end
  endtask

  task automatic test_slave_3c();
    int s_r, s_rxv;
    slave_mode = 1'b1;
    slave_byte = 8'h3C;
    s_r = rises; s_rxv = rxv_cnt;
    send_a(8'hFF, 1'b0);
    wait_idle_a("slave");
    checks++; if (rx_at(s_rxv) !== 8'h3C) begin errors++; $display("FAIL slave_rx_data: got %h want 3c", rx_at(s_rxv)); end
    checks++; if (mosi_byte(s_r) !== 8'hFF) begin errors++; $display("FAIL slave_mosi: got %h want ff", mosi_byte(s_r)); end
    slave_mode = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] d, want;
    int s_r, s_rxv;
    for (int i = 0; i < 8; i++) begin
      d = DW'($urandom_range(0, 255));
      slave_mode = 1'($urandom_range(0, 1));
      slave_byte = DW'($urandom_range(0, 255));
      want = slave_mode ? slave_byte : d;
      s_r = rises; s_rxv = rxv_cnt;
      send_a(d, 1'b0);
      wait_idle_a("rand");
      checks++; if (mosi_byte(s_r) !== d) begin errors++; $display("FAIL rand_mosi[%0d]: got %h want %h", i, mosi_byte(s_r), d); end
      checks++; if (rx_at(s_rxv) !== want || rxv_cnt - s_rxv != 1) begin
        errors++; $display("FAIL rand_rx[%0d]: got %h (%0d pulses) want %h (1 pulse)", i, rx_at(s_rxv), rxv_cnt - s_rxv, want);
      end
    end
    slave_mode = 1'b0;
  endtask

  task automatic test_burst();
    int s_r, s_low, s_rxv, s_sr, n;
    slave_mode = 1'b0;
    s_r = rises; s_low = ssel_low; s_rxv = rxv_cnt; s_sr = ssel_rises;
    @(negedge clk);
    bus_a.tx_data = 8'h12; bus_a.hold = 1'b1; bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_data = 8'h34;
    n = 0;
    while (bus_a.rx_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    checks++; if (n >= BOUND) begin errors++; $display("FAIL burst_last_timeout: rx_valid=%b want 1 within %0d cycles", bus_a.rx_valid, BOUND); end
    @(negedge clk);
    bus_a.tx_valid = 1'b0; bus_a.hold = 1'b0;
    wait_idle_a("burst");
    checks++; if (rises - s_r != 2 * DW) begin errors++; $display("FAIL burst_rises: got %0d want %0d", rises - s_r, 2 * DW); end
    checks++; if (rxv_cnt - s_rxv != 2) begin errors++; $display("FAIL burst_rxv_count: got %0d want 2", rxv_cnt - s_rxv); end
    checks++; if (rx_at(s_rxv) !== 8'h12 || rx_at(s_rxv + 1) !== 8'h34) begin
      errors++; $display("FAIL burst_rx_data: got %h %h want 12 34", rx_at(s_rxv), rx_at(s_rxv + 1));
    end
    checks++; if (mosi_byte(s_r) !== 8'h12 || mosi_byte(s_r + DW) !== 8'h34) begin
      errors++; $display("FAIL burst_mosi: got %h %h want 12 34", mosi_byte(s_r), mosi_byte(s_r + DW));
    end
    checks++; if (ssel_rises - s_sr != 1) begin errors++; $display("FAIL burst_ssel_rises: got %0d want 1", ssel_rises - s_sr); end
    checks++; if (s_sr >= ssel_rise_rxv_q.size() || ssel_rise_rxv_q[s_sr] != s_rxv + 2) begin
      errors++; $display("FAIL burst_ssel_after_last: got %0d rx_valid before SSEL rise want 2",
                         (s_sr < ssel_rise_rxv_q.size()) ? ssel_rise_rxv_q[s_sr] - s_rxv : -1);
    end
    checks++; if (ssel_low - s_low != 2 * model_ssel_low(DIV_A)) begin errors++; $display("FAIL burst_ssel_low: got %0d want %0d", ssel_low - s_low, 2 * model_ssel_low(DIV_A)); end
  endtask

  task automatic test_ignore();
    int s_r, s_rxv, s_sr, s_gap, n;
    slave_mode = 1'b0;
    s_r = rises; s_rxv = rxv_cnt; s_sr = ssel_rises;
    send_a(8'h6B, 1'b0);
    n = 0;
    while (rises - s_r < 3 && n < BOUND) begin @(negedge clk); n++; end
    bus_a.tx_data = 8'h99; bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    wait_idle_a("ignore");
    repeat (20) @(negedge clk);
    checks++; if (rises - s_r != DW) begin errors++; $display("FAIL ignore_rises: got %0d want %0d", rises - s_r, DW); end
    checks++; if (rxv_cnt - s_rxv != 1 || rx_at(s_rxv) !== 8'h6B) begin
      errors++; $display("FAIL ignore_rx: got %h (%0d pulses) want 6b (1 pulse)", rx_at(s_rxv), rxv_cnt - s_rxv);
    end
    checks++; if (ssel_rises - s_sr != 1) begin errors++; $display("FAIL ignore_ssel_rises: got %0d want 1", ssel_rises - s_sr); end
    s_r = rises; s_rxv = rxv_cnt; s_sr = ssel_rises; s_gap = gap_cyc;
    send_a(8'h4E, 1'b1);
    wait_idle_a("hold_novalid");
    bus_a.hold = 1'b0;
    checks++; if (rises - s_r != DW || rx_at(s_rxv) !== 8'h4E) begin
      errors++; $display("FAIL hold_novalid_xfer: got %0d rises rx %h want %0d rises rx 4e", rises - s_r, rx_at(s_rxv), DW);
    end
    checks++; if (ssel_rises - s_sr != 1 || gap_cyc - s_gap != DIV_A) begin
      errors++; $display("FAIL hold_novalid_gap: got %0d ssel rises %0d gap cycles want 1 and %0d", ssel_rises - s_sr, gap_cyc - s_gap, DIV_A);
    end
  endtask

  task automatic test_reset_mid();
    int s_r, s_rxv, n;
    slave_mode = 1'b0;
    s_r = rises; s_rxv = rxv_cnt;
    send_a(8'hC3, 1'b0);
    n = 0;
    while (rises - s_r < 4 && n < BOUND) begin @(negedge clk); n++; end
    checks++; if (n >= BOUND) begin errors++; $display("FAIL rstmid_wait: got %0d rises want 4 within %0d cycles", rises - s_r, BOUND); end
    rst_n_a = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.SCLK !== 1'b0 || bus_a.SSEL !== 1'b1) begin errors++; $display("FAIL rstmid_pins: got sclk=%b ssel=%b want 0/1", bus_a.SCLK, bus_a.SSEL); end
    checks++; if (bus_a.busy !== 1'b0 || bus_a.tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flags: got busy=%b tx_ready=%b want 0/1", bus_a.busy, bus_a.tx_ready); end
    @(negedge clk);
    rst_n_a = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (rxv_cnt != s_rxv) begin errors++; $display("FAIL rstmid_no_rxv: got %0d pulses want 0", rxv_cnt - s_rxv); end
    s_r = rises; s_rxv = rxv_cnt;
    send_a(8'h5A, 1'b0);
    wait_idle_a("after_rst");
    checks++; if (mosi_byte(s_r) !== 8'h5A || rx_at(s_rxv) !== 8'h5A) begin
      errors++; $display("FAIL after_rst_xfer: got mosi %h rx %h want 5a 5a", mosi_byte(s_r), rx_at(s_rxv));
    end
  endtask

  task automatic test_clk_div5();
    int s_r, s_hi, s_lo, s_setup, s_rxv, n, bad;
    s_r = b_rises; s_hi = b_high_q.size(); s_lo = b_low_q.size(); s_setup = b_setup; s_rxv = b_rxv;
    @(negedge clk);
    bus_b.tx_data = 8'h81; bus_b.hold = 1'b0; bus_b.tx_valid = 1'b1;
    @(negedge clk);
    bus_b.tx_valid = 1'b0;
    n = 0;
    while (!(bus_b.tx_ready === 1'b1 && bus_b.busy === 1'b0) && n < BOUND) begin @(negedge clk); n++; end
    checks++; if (n >= BOUND) begin errors++; $display("FAIL div5_timeout: busy=%b want idle within %0d cycles", bus_b.busy, BOUND); end
    bad = 0;
    for (int k = s_hi; k < b_high_q.size(); k++) if (b_high_q[k] != DIV_B) bad++;
    checks++; if (b_high_q.size() - s_hi != DW || bad != 0) begin
      errors++; $display("FAIL div5_high: got %0d high phases (%0d wrong length) want %0d of %0d cycles", b_high_q.size() - s_hi, bad, DW, DIV_B);
    end
    bad = 0;
    for (int k = s_lo; k < b_low_q.size(); k++) if (b_low_q[k] != DIV_B) bad++;
    checks++; if (b_low_q.size() - s_lo != DW - 1 || bad != 0) begin
      errors++; $display("FAIL div5_low: got %0d low phases (%0d wrong length) want %0d of %0d cycles", b_low_q.size() - s_lo, bad, DW - 1, DIV_B);
    end
    checks++; if (b_setup - s_setup != DIV_B) begin errors++; $display("FAIL div5_setup: got %0d want %0d", b_setup - s_setup, DIV_B); end
    checks++; if (b_rises - s_r != DW || b_rxv - s_rxv != 1 || b_rx !== 8'h81) begin
      errors++; $display("FAIL div5_xfer: got %0d rises %0d pulses rx %h want %0d 1 81", b_rises - s_r, b_rxv - s_rxv, b_rx, DW);
    end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_slave_3c();
    test_random();
    test_burst();
    test_ignore();
    test_reset_mid();
    test_clk_div5();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
